// File: rtl/shifter_pkg.sv
// ============================================================================
// Module   : shifter_pkg
// Brief    : Shift-mode encoding and pipeline step-distribution helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

   localparam int SH_MODE_W = 2;

   typedef enum logic [SH_MODE_W-1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROL = 2'b11
   } sh_mode_e;

   // Leftover binary steps go to the earliest stages.
   function automatic int stage_first(input int idx, input int nsteps, input int nstages);
      int base;
      int rem;
      base = nsteps / nstages;
      rem  = nsteps % nstages;
      return idx * base + ((idx < rem) ? idx : rem);
   endfunction

   function automatic int stage_count(input int idx, input int nsteps, input int nstages);
      int base;
      int rem;
      base = nsteps / nstages;
      rem  = nsteps % nstages;
      return base + ((idx < rem) ? 1 : 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_shifter_if.sv
// ============================================================================
// Module   : pipelined_shifter_if
// Brief    : Valid/ready operand and result bus of the pipelined shifter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipelined_shifter_if
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   sh_mode_e           in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_zero;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_zero
   );

endinterface

`default_nettype wire

// File: rtl/shifter_stage.sv
// ============================================================================
// Module   : shifter_stage
// Brief    : One register stage performing binary shift steps FIRST..FIRST+COUNT-1.
//            Rotate path built only with PIPELINED_SHIFTER_ROTATE_EN defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int FIRST   = 0,
   parameter int COUNT   = 1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_en,
   input  wire logic               i_valid,
   input  wire logic [WIDTH-1:0]   i_data,
   input  wire logic [SHAMT_W-1:0] i_shamt,
   input  wire sh_mode_e           i_mode,
   input  wire logic               i_msb,
   output logic                    o_valid,
   output logic [WIDTH-1:0]        o_data,
   output logic [SHAMT_W-1:0]      o_shamt,
   output sh_mode_e                o_mode,
   output logic                    o_msb
);

   logic [WIDTH-1:0]   w_data;
   logic [SHAMT_W-1:0] w_bits;

   logic               r_valid;
   logic [WIDTH-1:0]   r_data;
   logic [SHAMT_W-1:0] r_shamt;
   sh_mode_e           r_mode;
   logic               r_msb;

   // SRA fills from the operand's original sign, not the partially shifted word.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input int               amt,
      input sh_mode_e         m,
      input logic             msb
   );
      logic [WIDTH-1:0] fill;
      fill = ~({WIDTH{1'b1}} >> amt);
      case (m)
         SH_SRL:  return d >> amt;
         SH_SRA:  return (d >> amt) | (msb ? fill : '0);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
         SH_ROL:  return (d << amt) | (d >> (WIDTH - amt));
`endif
         default: return d << amt;
      endcase
   endfunction

   always_comb begin
      w_data = i_data;
      w_bits = i_shamt >> FIRST;
      for (int k = FIRST; k < FIRST + COUNT; k++) begin
         if (w_bits[0]) begin
            w_data = shift_step(w_data, 1 << k, i_mode, i_msb);
         end
         w_bits = w_bits >> 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
         r_mode  <= SH_SLL;
         r_msb   <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data  <= w_data;
            r_shamt <= i_shamt;
            r_mode  <= i_mode;
            r_msb   <= i_msb;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;
   assign o_mode  = r_mode;
   assign o_msb   = r_msb;

endmodule

`default_nettype wire

// File: rtl/pipelined_shifter.sv
// ============================================================================
// Module   : pipelined_shifter
// Brief    : Valid/ready pipelined SLL/SRL/SRA/ROL unit, STAGES register stages.
//            Define PIPELINED_SHIFTER_ROTATE_EN to build ROL; otherwise mode 11 = SLL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pipelined_shifter_if.slave bus
);

   localparam int SHAMT_W = $clog2(WIDTH);

   logic               w_valid [0:STAGES];
   logic [WIDTH-1:0]   w_data  [0:STAGES];
   logic [SHAMT_W-1:0] w_shamt [0:STAGES];
   sh_mode_e           w_mode  [0:STAGES];
   logic               w_msb   [0:STAGES];
   logic [STAGES-1:0]  w_en;
   logic               w_full;

   assign w_valid[0] = bus.in_valid;
   assign w_data[0]  = bus.in_data;
   assign w_shamt[0] = bus.in_shamt;
   assign w_mode[0]  = bus.in_mode;
   assign w_msb[0]   = bus.in_data[WIDTH-1];

   // A stage may load unless it and every stage after it are full and the output stalls.
   always_comb begin
      w_full = 1'b1;
      w_en   = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         w_full  = w_full & w_valid[i+1];
         w_en[i] = !w_full || bus.out_ready;
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      shifter_stage #(
         .WIDTH   (WIDTH),
         .SHAMT_W (SHAMT_W),
         .FIRST   (stage_first(gi, SHAMT_W, STAGES)),
         .COUNT   (stage_count(gi, SHAMT_W, STAGES))
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_en    (w_en[gi]),
         .i_valid (w_valid[gi]),
         .i_data  (w_data[gi]),
         .i_shamt (w_shamt[gi]),
         .i_mode  (w_mode[gi]),
         .i_msb   (w_msb[gi]),
         .o_valid (w_valid[gi+1]),
         .o_data  (w_data[gi+1]),
         .o_shamt (w_shamt[gi+1]),
         .o_mode  (w_mode[gi+1]),
         .o_msb   (w_msb[gi+1])
      );
   end

   assign bus.in_ready  = w_en[0];
   assign bus.out_valid = w_valid[STAGES];
   assign bus.out_data  = w_data[STAGES];
   assign bus.out_zero  = ~|w_data[STAGES];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
// ============================================================================
// Module   : tb_pipelined_shifter
// Brief    : Self-checking bench: directed vectors, backpressure, random stalls, reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_shifter;
   import shifter_pkg::*;

   localparam int WIDTH   = 32;
   localparam int STAGES  = 2;
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int N_RAND  = 10000;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
   localparam logic [31:0] ROL_EXP = 32'h0000_0003;
`else
   localparam logic [31:0] ROL_EXP = 32'h0000_0002;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_shifter_if #(.WIDTH(WIDTH)) bus ();

   pipelined_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   int          consumed;
   logic        stalled;
   logic [31:0] held;
   logic        acc_flag;
   logic        rdy_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input int m);
      logic [63:0] w;
      case (m)
         1:       return d >> s;
         2:       return 32'($signed(d) >>> s);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
         3: begin
            w = {d, d} << s;
            return w[63:32];
         end
`endif
         default: return d << s;
      endcase
   endfunction

   // One clock: sample at negedge, score accepts/results, return at posedge+1.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      if (stalled) begin
         check("hold_valid", bus.out_valid, 1);
         check("hold_data", bus.out_data, held);
      end
      acc_flag = bus.in_valid && bus.in_ready;
      rdy_seen = bus.in_ready;
      if (acc_flag)
         exp_q.push_back(ref_shift(bus.in_data, int'(bus.in_shamt), int'(bus.in_mode)));
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", bus.out_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check("data", bus.out_data, e);
            check("zero", bus.out_zero, (e == 0));
         end
         consumed++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      bus.in_data  = $urandom;
      bus.in_shamt = SHAMT_W'($urandom_range(0, WIDTH - 1));
      bus.in_mode  = sh_mode_e'($urandom_range(0, 3));
   endtask

   task automatic send_one(input string tag, input logic [31:0] d, input int s,
                           input int m, input logic [31:0] exp);
      logic [SHAMT_W-1:0] sh;
      logic [1:0]         md;
      int                 lat;
      sh = SHAMT_W'(s);
      md = 2'(m);
      bus.out_ready = 1'b1;
      bus.in_data   = d;
      bus.in_shamt  = sh;
      bus.in_mode   = sh_mode_e'(md);
      bus.in_valid  = 1'b1;
      @(negedge clk);
      check({tag, "_rdy"}, bus.in_ready, 1);
      check({tag, "_idle"}, bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (lat < 20) begin
         @(negedge clk);
         if (bus.out_valid) break;
         lat++;
      end
      check({tag, "_lat"}, lat, STAGES);
      check({tag, "_data"}, bus.out_data, exp);
      check({tag, "_zero"}, bus.out_zero, (exp == 0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int stall_at;
      int cyc;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_mode   = SH_SLL;
      bus.out_ready = 1'b0;
      stalled       = 1'b0;
      consumed      = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_zero", bus.out_zero, 1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      send_one("sll2",    32'h0000_0001,  2, 0, 32'h0000_0004);
      send_one("sra31",   32'h8000_0000, 31, 2, 32'hFFFF_FFFF);
      send_one("srl31",   32'h8000_0000, 31, 1, 32'h0000_0001);
      send_one("sll31",   32'h0000_0001, 31, 0, 32'h8000_0000);
      send_one("rol1",    32'h8000_0001,  1, 3, ROL_EXP);
      send_one("sll32",   32'h0000_0001, 32, 0, 32'h0000_0001);
      send_one("sll_out", 32'h8000_0000,  1, 0, 32'h0000_0000);
      send_one("sra0",    32'h8765_4321,  0, 2, 32'h8765_4321);

      // Backpressure: five beats against a stalled output.
      exp_q.delete();
      consumed      = 0;
      acc           = 0;
      stall_at      = -1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      rand_beat();
      for (int c = 0; c < 8; c++) begin
         step();
         if (acc_flag) begin
            acc++;
            rand_beat();
         end
         if (!rdy_seen && stall_at < 0) stall_at = acc;
      end
      check("bp_stall_at", stall_at, STAGES);
      check("bp_in_flight", exp_q.size(), STAGES);
      check("bp_no_out", consumed, 0);
      bus.out_ready = 1'b1;
      cyc = 0;
      while ((acc < 5 || exp_q.size() > 0) && cyc < 40) begin
         step();
         if (acc_flag) begin
            acc++;
            rand_beat();
         end
         bus.in_valid = (acc < 5);
         cyc++;
      end
      check("bp_drained", consumed, 5);
      check("bp_queue_empty", exp_q.size(), 0);

      // Random valid/ready traffic.
      consumed = 0;
      acc      = 0;
      cyc      = 0;
      bus.in_valid = 1'b0;
      while ((acc < N_RAND || exp_q.size() > 0) && cyc < 60000) begin
         bus.out_ready = ($urandom_range(0, 9) < 7);
         if (!bus.in_valid && acc < N_RAND) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            rand_beat();
         end
         step();
         if (acc_flag) begin
            acc++;
            bus.in_valid = 1'b0;
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("rand_count", consumed, N_RAND);
      check("rand_queue_empty", exp_q.size(), 0);

      // Reset with two beats in flight.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      rand_beat();
      acc = 0;
      cyc = 0;
      while (acc < 2 && cyc < 10) begin
         step();
         if (acc_flag) begin
            acc++;
            rand_beat();
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("mid_pre_valid", bus.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_out_valid", bus.out_valid, 0);
      check("mid_out_data", bus.out_data, 0);
      check("mid_out_zero", bus.out_zero, 1);
      exp_q.delete();
      stalled = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_in_ready", bus.in_ready, 1);
      check("mid_no_stale", bus.out_valid, 0);
      @(posedge clk);
      #1;
      send_one("post_rst", 32'h0000_00F0, 4, 1, 32'h0000_000F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined shift unit for the CPU datapath. Generalises the fixed shift-left-by-two used in branch-target and jump-address generation to any width, any run-time shift amount, and four shift modes. A valid/ready handshake lets it sit between the ID/EX operand latch and the EX/MEM register, including under stall backpressure. Latency is a configurable number of register stages.

## Interface
- WIDTH, 32, operand width in bits; power of two, 8..64.
- STAGES, 2, register stages; 1..log2(WIDTH).
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.

## Operation
- The shift is decomposed into log2(WIDTH) binary steps: step k shifts by 2^k when in_shamt[k] is set.
- Steps are distributed over STAGES register stages as evenly as possible, with any remainder steps placed in the earliest stages.
- Each stage carries valid, data, the remaining shamt bits, and mode.
- SLL zero-fills. SRL zero-fills. SRA fills with the operand's original MSB, which is carried through the pipeline. ROL wraps the MSBs into the LSBs.
- in_shamt = 0 passes the operand unchanged in every mode.
- Handshake: beat accepted when in_valid && in_ready. Result consumed when out_valid && out_ready.
- Stage enable: en[last] = !v[last] || out_ready. en[i] = !v[i] || en[i+1]. in_ready = en[0]. Bubbles collapse, so a stalled output does not block empty upstream stages.
- out_data, out_zero and out_valid are held stable while out_valid && !out_ready.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- There is no FSM. State is only the per-stage valid bits and payloads.

## Timing
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N+STAGES, provided there is no backpressure.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_* to out_*.
- Capacity: STAGES beats in flight. With out_ready held low, in_ready falls after STAGES accepts.
- Simultaneous consume and accept when full: allowed. Occupancy stays the same.
- Reset (any time, including mid-operation): all valid bits go to 0 and all payload registers go to 0 immediately.
  - out_valid = 0, out_data = 0, out_zero = 1.
  - in_ready = 1 from the first cycle after rst deasserts.
  - In-flight beats are discarded.

## Configuration
- PIPELINED_SHIFTER_ROTATE_EN defined: mode 11 performs ROL as described.
- Not defined: the rotate wrap path is not built. Mode 11 executes as SLL, and the saved logic is removed.
- All other behaviour is identical in both builds.

## Structure
- shifter_pkg: mode enum (SH_SLL, SH_SRL, SH_SRA, SH_ROL) and the mode width constant. The ID stage shares this package.
- Sub-module shifter_stage: one register stage. It is parameterised by its first step index and step count, and performs its binary steps plus the valid/enable logic. The top instantiates STAGES copies in a generate loop.

## Test plan
- SLL: 0x0000_0001, shamt 2, STAGES 2 -> 0x0000_0004 with out_valid 2 cycles after accept. This matches the legacy shift-left-two result.
- SRA: 0x8000_0000, shamt 31 -> 0xFFFF_FFFF. SRL of the same operand -> 0x0000_0001. SLL 0x1, shamt 31 -> 0x8000_0000.
- ROL: 0x8000_0001, shamt 1 -> 0x0000_0003 with the macro defined, and 0x0000_0002 without it. SLL 0x1, shamt 32 wraps to shamt 0 -> 0x0000_0001, out_zero = 0. SLL 0x8000_0000, shamt 1 -> 0x0, out_zero = 1.
- Backpressure: out_ready = 0, stream 5 beats -> in_ready drops after 2 accepts. Outputs stay stable. Releasing out_ready drains all 5 beats in order, with no loss and no duplicates.
- Random stall: random in_valid/out_ready over 10k beats with all modes and shamts -> scoreboard matches the reference model and order is preserved.
- Reset mid-operation: assert rst with 2 beats in flight -> out_valid = 0, out_data = 0 in the same cycle. After release, in_ready = 1, and the next beat produces the correct result with no stale output.
